// File: rtl/light_pkg.sv
// Shared types and constants for the light sequencer: state encoding,
// grant codes, per-sequence base light codes and the round-robin picker.
package light_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        GR_NONE = 2'b00,
        GR_A    = 2'b01,
        GR_B    = 2'b10,
        GR_C    = 2'b11
    } grant_e;

    localparam logic [3:0] BASE_A = 4'd1;
    localparam logic [3:0] BASE_B = 4'd4;
    localparam logic [3:0] BASE_C = 4'd7;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] src;
    } pick_t;

    function automatic logic [3:0] base_code(input grant_e g);
        logic [3:0] b;
        case (g)
            GR_A:    b = BASE_A;
            GR_B:    b = BASE_B;
            GR_C:    b = BASE_C;
            default: b = 4'd0;
        endcase
        return b;
    endfunction

    function automatic grant_e grant_of(input logic [1:0] src);
        grant_e g;
        case (src)
            SRC_A:   g = GR_A;
            SRC_B:   g = GR_B;
            SRC_C:   g = GR_C;
            default: g = GR_NONE;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] src_mask(input logic [1:0] src);
        logic [2:0] m;
        case (src)
            SRC_A:   m = 3'b001;
            SRC_B:   m = 3'b010;
            SRC_C:   m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Scan sources starting just after the last grant; first eligible wins.
    function automatic pick_t rr_pick(input logic [2:0] elig, input logic [1:0] last);
        pick_t p;
        int    idx;
        p.valid = 1'b0;
        p.src   = SRC_A;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last) + k) % 3;
            if (!p.valid && elig[idx]) begin
                p.valid = 1'b1;
                p.src   = idx[1:0];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/light_prescaler.sv
// Step prescaler: counts DIV cycles and pulses tick on the last one.
// clr holds the count at zero so each sequence starts on a full step.
module light_prescaler
    import light_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_r;

    assign tick = !clr && (cnt_r == LAST);

    // Cycle counter, wraps after LAST.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (cnt_r == LAST) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/light_sched.sv
// Round-robin light sequencer: serves requests A/B/C, each as three lit
// steps of DIV cycles followed by a DIV-cycle dark gap.
module light_sched
    import light_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_c,
    input  logic       cancel,
    output logic [3:0] y,
    output logic [1:0] grant,
    output logic       busy,
    output logic [2:0] pend
);

    state_e     state_r, state_s;
    logic [1:0] step_r, step_s;
    logic [1:0] last_r, last_s;
    logic [3:0] y_r, y_s;
    grant_e     grant_r, grant_s;
    logic       busy_r, busy_s;
    logic [2:0] pend_r, pend_s;

    logic [2:0] req_s;
    pick_t      pick_s;
    logic       clr_s;
    logic       tick_s;

    assign req_s  = {req_c, req_b, req_a};
    assign pick_s = rr_pick(pend_r | req_s, last_r);
    assign clr_s  = (state_r != ST_RUN) && (state_r != ST_GAP);

    light_prescaler #(.DIV(DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        last_s  = last_r;
        y_s     = y_r;
        grant_s = grant_r;
        busy_s  = busy_r;
        pend_s  = pend_r | req_s;
        if (cancel) begin
            state_s = ST_IDLE;
            step_s  = 2'd0;
            pend_s  = 3'b000;
            y_s     = 4'd0;
            grant_s = GR_NONE;
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_s.valid) begin
                        state_s = ST_RUN;
                        step_s  = 2'd0;
                        last_s  = pick_s.src;
                        grant_s = grant_of(pick_s.src);
                        y_s     = base_code(grant_of(pick_s.src));
                        busy_s  = 1'b1;
                        pend_s  = (pend_r | req_s) & ~src_mask(pick_s.src);
                    end else begin
                        state_s = ST_IDLE;
                        step_s  = 2'd0;
                        y_s     = 4'd0;
                        grant_s = GR_NONE;
                        busy_s  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        if (step_r == 2'd2) begin
                            state_s = ST_GAP;
                            step_s  = 2'd0;
                            y_s     = 4'd0;
                        end else begin
                            step_s  = step_r + 2'd1;
                            y_s     = base_code(grant_r) + {2'b00, step_r} + 4'd1;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_GAP: begin
                    if (tick_s) begin
                        state_s = ST_IDLE;
                        y_s     = 4'd0;
                        grant_s = GR_NONE;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    step_s  = 2'd0;
                    y_s     = 4'd0;
                    grant_s = GR_NONE;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; pointer resets to C so A wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            step_r  <= 2'd0;
            last_r  <= SRC_C;
            y_r     <= 4'd0;
            grant_r <= GR_NONE;
            busy_r  <= 1'b0;
            pend_r  <= 3'b000;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            last_r  <= last_s;
            y_r     <= y_s;
            grant_r <= grant_s;
            busy_r  <= busy_s;
            pend_r  <= pend_s;
        end
    end

    assign y     = y_r;
    assign grant = grant_r;
    assign busy  = busy_r;
    assign pend  = pend_r;

endmodule

// File: tb/tb_light_sched.sv
// Bench for light_sched: a time-based reference model checked every cycle,
// plus directed scenarios with literal expectations (DIV=4 and DIV=1 builds).
module tb_light_sched;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset, req_a, req_b, req_c, cancel;
    logic [3:0] y;
    logic [1:0] grant;
    logic       busy;
    logic [2:0] pend;

    logic       reset1, req_c1;
    logic [3:0] y1;
    logic [1:0] grant1;
    logic       busy1;
    logic [2:0] pend1;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    light_sched #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .cancel(cancel), .y(y), .grant(grant), .busy(busy), .pend(pend)
    );

    light_sched #(.DIV(1)) dut1 (
        .clk(clk), .reset(reset1), .req_a(1'b0), .req_b(1'b0), .req_c(req_c1),
        .cancel(1'b0), .y(y1), .grant(grant1), .busy(busy1), .pend(pend1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: active source and cycles elapsed since its grant.
    int         m_act = -1;
    int         m_t = 0;
    int         m_last = 2;
    logic [2:0] m_pend = 3'b000;

    always @(posedge clk) begin : model_upd
        logic [2:0] r, e, oh;
        int pick;
        r = {req_c, req_b, req_a};
        if (!reset) begin
            m_act <= -1; m_t <= 0; m_pend <= 3'b000; m_last <= 2;
        end else if (cancel) begin
            m_act <= -1; m_t <= 0; m_pend <= 3'b000;
        end else if (m_act >= 0) begin
            m_pend <= m_pend | r;
            if (m_t + 1 >= 4 * DIV) m_act <= -1;
            else m_t <= m_t + 1;
        end else begin
            e = m_pend | r;
            pick = -1;
            for (int k = 1; k <= 3; k++)
                if (pick < 0 && e[(m_last + k) % 3]) pick = (m_last + k) % 3;
            if (pick >= 0) begin
                oh = 3'b001 << pick;
                m_act <= pick; m_t <= 0; m_last <= pick;
                m_pend <= e & ~oh;
            end else begin
                m_pend <= e;
            end
        end
    end

    always @(negedge clk) begin : compare
        int ey, eg, eb;
        if (check_en) begin
            eb = (m_act >= 0) ? 1 : 0;
            eg = (m_act >= 0) ? m_act + 1 : 0;
            ey = (m_act >= 0 && m_t < 3 * DIV) ? 1 + 3 * m_act + m_t / DIV : 0;
            chk("model_y", y, ey);
            chk("model_grant", grant, eg);
            chk("model_busy", busy, eb);
            chk("model_pend", pend, m_pend);
        end
    end

    int exp28[17] = '{1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,0};
    int exp33[5]  = '{7,8,9,0,0};

    initial begin
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; cancel = 1'b0;
        reset1 = 1'b0; req_c1 = 1'b0;
        cyc(1);
        check_en = 1'b1;
        cyc(1);
        reset = 1'b1;
        chk("rst_y", y, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend, 0);
        cyc(2);

        // single A sequence
        req_a = 1'b1; cyc(1); req_a = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk("seqA_y", y, exp28[i]);
            chk("seqA_busy", busy, (i < 16) ? 1 : 0);
            chk("seqA_grant", grant, (i < 16) ? 1 : 0);
            cyc(1);
        end

        // simultaneous A,B,C after reset
        reset = 1'b0; cyc(1); reset = 1'b1;
        req_a = 1'b1; req_b = 1'b1; req_c = 1'b1; cyc(1);
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        chk("abc_grantA", grant, 1); chk("abc_pend110", pend, 3'b110);
        cyc(17);
        chk("abc_grantB", grant, 2); chk("abc_pend100", pend, 3'b100);
        cyc(17);
        chk("abc_grantC", grant, 3); chk("abc_pend000", pend, 3'b000);
        cyc(17);

        // B held, A pulses during B's run
        req_b = 1'b1; cyc(1);
        chk("rr_grantB", grant, 2);
        cyc(4); req_a = 1'b1; cyc(1); req_a = 1'b0;
        chk("rr_pend011", pend, 3'b011);
        cyc(12);
        chk("rr_grantA_before_B", grant, 1);
        req_b = 1'b0;
        cyc(17);
        chk("rr_grantB_again", grant, 2);
        cyc(19);

        // cancel at step 1 of C with A,B pending
        req_c = 1'b1; cyc(1); req_c = 1'b0;
        req_a = 1'b1; req_b = 1'b1; cyc(1); req_a = 1'b0; req_b = 1'b0;
        cyc(3);
        chk("can_y8", y, 8); chk("can_pend011", pend, 3'b011);
        cancel = 1'b1; req_c = 1'b1; cyc(1); cancel = 1'b0; req_c = 1'b0;
        chk("can_y", y, 0); chk("can_busy", busy, 0);
        chk("can_pend", pend, 0); chk("can_grant", grant, 0);
        cyc(2);
        req_a = 1'b1; cyc(1); req_a = 1'b0;
        chk("can_after_y", y, 1); chk("can_after_grant", grant, 1);

        // reset during GAP
        cyc(13);
        chk("gap_y", y, 0); chk("gap_busy", busy, 1);
        reset = 1'b0; cyc(1); reset = 1'b1;
        chk("gaprst_y", y, 0); chk("gaprst_grant", grant, 0);
        chk("gaprst_busy", busy, 0); chk("gaprst_pend", pend, 0);
        req_a = 1'b1; req_b = 1'b1; cyc(1); req_a = 1'b0; req_b = 1'b0;
        chk("gaprst_grantA", grant, 1); chk("gaprst_pend010", pend, 3'b010);
        cyc(40);

        // DIV=1 build
        reset1 = 1'b1; cyc(1);
        req_c1 = 1'b1; cyc(1); req_c1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("div1_y", y1, exp33[i]);
            chk("div1_busy", busy1, (i < 4) ? 1 : 0);
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
